sar_search_controller: RTL and testbench

SAR_SEARCH_CONTROLLER -- requirements
Module: sar_search_controller

---
 rtl/sar_search_controller.sv | 220 ++++++++++++++++++++++
 tb/tb_sar_search_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_controller.sv
// sar_search_controller
// Successive-approximation search engine. Drives a probe value to an external
// comparator, samples its GT/LT/EQ flags and refines the probe one bit per
// probe, MSB first, until the result is resolved.
//
// Parameters
//   WIDTH  : bit width of guess/result (2..16)
//   SETTLE : extra cycles each probe is held before the flags are sampled (0..7)
//
// Ports
//   clk     in   clock, all state changes on the rising edge
//   rst     in   synchronous active-high reset
//   start   in   begin a search (accepted only while idle)
//   GT      in   comparator flag: guess > target
//   LT      in   comparator flag: guess < target
//   EQ      in   comparator flag: guess == target
//   guess   out  registered probe value to the comparator
//   busy    out  high while probing
//   done    out  one-cycle pulse at end of search
//   result  out  final search value, held until the next accepted start
//   err     out  non-one-hot comparator flags seen during the last search
//   probes  out  number of probes evaluated in the last search
//
// Configuration macro
//   SAR_EARLY_EXIT_EN : when defined, an EQ-only sample ends the search at once.
//                       When undefined, EQ behaves like LT and all WIDTH probes run.

module sar_search_controller #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       GT,
  input  logic                       LT,
  input  logic                       EQ,
  output logic [WIDTH-1:0]           guess,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           result,
  output logic                       err,
  output logic [$clog2(WIDTH+1)-1:0] probes
);

  localparam int PW = $clog2(WIDTH + 1);
  localparam int IW = $clog2(WIDTH);
  localparam int SW = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  guess_q, guess_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              err_q, err_d;
  logic [PW-1:0]     probes_q, probes_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              sample_s;
  logic              legal_s;
  logic              early_s;
  logic              last_bit_s;
  logic [WIDTH-1:0]  upd_s;

  // Exactly one comparator flag must be set for a sample to be trusted.
  function automatic logic is_onehot3(input logic [2:0] f);
    logic r;
    case (f)
      3'b001, 3'b010, 3'b100: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  // Flags are sampled only in the final cycle of the settle window.
  assign sample_s   = (state_q == S_PROBE) && (settle_q == SW'(SETTLE));
  assign legal_s    = is_onehot3({GT, LT, EQ});
  assign last_bit_s = (idx_q == {IW{1'b0}});

`ifdef SAR_EARLY_EXIT_EN
  assign early_s = legal_s & EQ;
`else
  assign early_s = 1'b0;
`endif

  // Probe value after applying the comparator decision to the current bit:
  // GT clears it, LT (and EQ) keep it.
  always_comb begin
    upd_s = guess_q;
    if (legal_s && GT) begin
      upd_s[idx_q] = 1'b0;
    end else begin
      upd_s = guess_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_PROBE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PROBE: begin
        if (sample_s && (!legal_s || early_s || last_bit_s)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_PROBE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    guess_d  = guess_q;
    result_d = result_q;
    err_d    = err_q;
    probes_d = probes_q;
    settle_d = settle_q;
    idx_d    = idx_q;
    busy_d   = (state_d == S_PROBE);
    done_d   = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          guess_d  = {1'b1, {(WIDTH-1){1'b0}}};
          idx_d    = IW'(WIDTH - 1);
          probes_d = {PW{1'b0}};
          settle_d = {SW{1'b0}};
          err_d    = 1'b0;
        end else begin
          guess_d = guess_q;
        end
      end
      S_PROBE: begin
        if (sample_s) begin
          probes_d = probes_q + PW'(1);
          settle_d = {SW{1'b0}};
          if (!legal_s) begin
            // Untrusted flags: report the probe that was on the bus.
            err_d    = 1'b1;
            result_d = guess_q;
          end else if (early_s) begin
            result_d = guess_q;
          end else if (last_bit_s) begin
            guess_d  = upd_s;
            result_d = upd_s;
          end else begin
            // Tentatively set the next lower bit for the following probe.
            guess_d                   = upd_s;
            guess_d[idx_q - IW'(1)]   = 1'b1;
            idx_d                     = idx_q - IW'(1);
          end
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      S_DONE: begin
        guess_d = guess_q;
      end
      default: begin
        guess_d = guess_q;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      guess_q  <= {WIDTH{1'b0}};
      result_q <= {WIDTH{1'b0}};
      err_q    <= 1'b0;
      probes_q <= {PW{1'b0}};
      settle_q <= {SW{1'b0}};
      idx_q    <= {IW{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      guess_q  <= guess_d;
      result_q <= result_d;
      err_q    <= err_d;
      probes_q <= probes_d;
      settle_q <= settle_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign guess  = guess_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign err    = err_q;
  assign probes = probes_q;

endmodule

// File: tb/tb_sar_search_controller.sv
// Testbench for sar_search_controller: two instances (SETTLE=0 and SETTLE=2),
// each with a behavioural comparator, checked cycle by cycle against a
// binary-search reference model.

module tb_sar_search_controller;

  localparam int W  = 4;
  localparam int PW = $clog2(W + 1);

`ifdef SAR_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          sel;
  logic          start_v;
  logic          start0, start1;
  logic [W-1:0]  tgt0, tgt1;
  int            force0;

  logic          gt0, lt0, eq0, gt1, lt1, eq1;
  logic [W-1:0]  guess0, result0, guess1, result1;
  logic          busy0, done0, err0, busy1, done1, err1;
  logic [PW-1:0] probes0, probes1;
  logic          forcing0;

  int n_vec = 0;
  int n_err = 0;

  assign start0 = start_v & ~sel;
  assign start1 = start_v & sel;

  // Behavioural comparators; instance 0 can be forced to GT=LT=1 on one probe.
  assign forcing0 = (force0 != 0) && busy0 && (int'(probes0) == force0 - 1);
  assign gt0 = forcing0 ? 1'b1 : (guess0 > tgt0);
  assign lt0 = forcing0 ? 1'b1 : (guess0 < tgt0);
  assign eq0 = forcing0 ? 1'b0 : (guess0 == tgt0);
  assign gt1 = (guess1 > tgt1);
  assign lt1 = (guess1 < tgt1);
  assign eq1 = (guess1 == tgt1);

  sar_search_controller #(.WIDTH(W), .SETTLE(0)) dut (
    .clk(clk), .rst(rst), .start(start0), .GT(gt0), .LT(lt0), .EQ(eq0),
    .guess(guess0), .busy(busy0), .done(done0), .result(result0),
    .err(err0), .probes(probes0)
  );

  sar_search_controller #(.WIDTH(W), .SETTLE(2)) dut_s2 (
    .clk(clk), .rst(rst), .start(start1), .GT(gt1), .LT(lt1), .EQ(eq1),
    .guess(guess1), .busy(busy1), .done(done1), .result(result1),
    .err(err1), .probes(probes1)
  );

  logic [W-1:0]  o_guess, o_result;
  logic          o_busy, o_done, o_err;
  logic [PW-1:0] o_probes;
  assign o_guess  = sel ? guess1  : guess0;
  assign o_result = sel ? result1 : result0;
  assign o_busy   = sel ? busy1   : busy0;
  assign o_done   = sel ? done1   : done0;
  assign o_err    = sel ? err1    : err0;
  assign o_probes = sel ? probes1 : probes0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_guess0"},  32'(guess0),  32'd0);
    check_eq({tag, "_result0"}, 32'(result0), 32'd0);
    check_eq({tag, "_busy0"},   32'(busy0),   32'd0);
    check_eq({tag, "_done0"},   32'(done0),   32'd0);
    check_eq({tag, "_err0"},    32'(err0),    32'd0);
    check_eq({tag, "_probes0"}, 32'(probes0), 32'd0);
    check_eq({tag, "_busy1"},   32'(busy1),   32'd0);
    check_eq({tag, "_result1"}, 32'(result1), 32'd0);
  endtask

  // One search on instance s with target t; f>0 corrupts the flags on probe f.
  task automatic run_search(input bit s, input logic [W-1:0] t, input int f);
    int           st;
    logic [W-1:0] trials[$];
    logic [W-1:0] res, trial, one;
    bit           e;
    int           np, lat;
    st  = s ? 3 : 1;
    one = 1;
    res = '0;
    e   = 1'b0;
    trials.delete();
    // Reference: classic MSB-first trial-and-keep binary search.
    for (int b = W - 1; b >= 0; b--) begin
      trial = res | (one << b);
      trials.push_back(trial);
      if (trials.size() == f) begin
        e   = 1'b1;
        res = trial;
        break;
      end
      if (EARLY && trial == t) begin
        res = trial;
        break;
      end
      if (trial <= t) res = trial;
    end
    np  = trials.size();
    lat = np * st + 1;

    @(negedge clk);
    sel = s;
    if (s) tgt1 = t;
    else begin
      tgt0   = t;
      force0 = f;
    end
    start_v = 1'b1;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k < lat) begin
        check_eq("probe_guess", 32'(o_guess), 32'(trials[(k - 1) / st]));
        check_eq("probe_busy",  32'(o_busy),  32'd1);
        check_eq("probe_done",  32'(o_done),  32'd0);
        check_eq("probe_err",   32'(o_err),   32'd0);
      end else if (k == lat) begin
        check_eq("done_pulse",  32'(o_done),   32'd1);
        check_eq("done_busy",   32'(o_busy),   32'd0);
        check_eq("done_result", 32'(o_result), 32'(res));
        check_eq("done_err",    32'(o_err),    32'(e));
        check_eq("done_probes", 32'(o_probes), 32'(np));
        check_eq("done_guess",  32'(o_guess),  32'(res));
      end else begin
        check_eq("post_done",   32'(o_done),   32'd0);
        check_eq("post_result", 32'(o_result), 32'(res));
        check_eq("post_guess",  32'(o_guess),  32'(res));
      end
      // Start pulses while probing must be ignored.
      start_v = (k < lat) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    force0 = 0;
  endtask

  initial begin
    rst     = 1'b1;
    sel     = 1'b0;
    start_v = 1'b0;
    tgt0    = '0;
    tgt1    = '0;
    force0  = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Reset wins over start.
    start_v = 1'b1;
    @(negedge clk);
    check_eq("rst_prio_busy", 32'(busy0), 32'd0);
    rst     = 1'b0;
    start_v = 1'b0;
    @(negedge clk);

    // Directed searches.
    run_search(1'b0, 4'd11, 0);
    run_search(1'b0, 4'd8,  0);
    run_search(1'b0, 4'd0,  0);
    run_search(1'b0, 4'd15, 0);
    run_search(1'b0, 4'd11, 2);
    run_search(1'b0, 4'd6,  0);
    run_search(1'b1, 4'd5,  0);

    // Reset during the third probe: idle next cycle, no done afterwards.
    @(negedge clk);
    sel     = 1'b0;
    tgt0    = 4'd11;
    start_v = 1'b1;
    @(negedge clk);
    start_v = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("midrst_nodone", 32'(done0), 32'd0);
      check_eq("midrst_idle",   32'(busy0), 32'd0);
    end

    // Randomized searches on both instances.
    for (int i = 0; i < 24; i++) begin
      run_search(1'b0, 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 4)) : 0);
    end
    for (int i = 0; i < 5; i++) begin
      run_search(1'b1, 4'($urandom_range(0, 15)), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
